// File: rtl/updown_counter_mod.sv
// rtl/updown_counter_mod.sv - parametrised up/down event counter with prescaler, load, tc and sticky ovf
module updown_counter_mod #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 255,
  parameter int unsigned SATURATE = 0,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam int unsigned     PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam longint unsigned CAP     = (64'd1 << WIDTH) - 64'd1;
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [PW-1:0]   PS_LAST = PW'(PRESCALE - 1);

  if (WIDTH < 1) begin : g_bad_width
    $error("updown_counter_mod: WIDTH must be >= 1");
  end
  if (64'(MAX_VAL) > CAP) begin : g_bad_max
    $error("updown_counter_mod: MAX_VAL exceeds 2**WIDTH-1");
  end
  if (PRESCALE == 0) begin : g_bad_prescale
    $error("updown_counter_mod: PRESCALE must be >= 1");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             at_bound;

  always_comb begin
    count_d  = count_q;
    pre_d    = pre_q;
    tc_d     = 1'b0;
    ovf_d    = ovf_q & ~clr_ovf;
    at_bound = up ? (count_q == MAX_W) : (count_q == '0);
    if (load) begin
      count_d = (load_val > MAX_W) ? MAX_W : load_val;
      pre_d   = '0;
    end else if (en) begin
      if (pre_q == PS_LAST) begin
        pre_d = '0;
        // Boundary step: set wins over a simultaneous clr_ovf.
        if (at_bound) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          if (SATURATE == 0) count_d = up ? '0 : MAX_W;
        end else begin
          count_d = up ? count_q + 1'b1 : count_q - 1'b1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      pre_q   <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule
